// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU: 3-bit op codes
//               (unchanged from the combinational ALU) and FSM states.
//               Build option: ALU_MUL_EN enables the iterative multiply.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } aluState_t;

endpackage

`default_nettype wire

// File: rtl/alu_comb_core.sv
//------------------------------------------------------------------------------
// Module      : alu_comb_core
// Description : Combinational AND/OR/ADD/SUB/SLT with carry and signed
//               overflow. Iterative op codes produce all-zero outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    input  logic [2:0]       aluOp,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // Extended-width adders; the top bit is the carry out.
    assign w_sum  = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, carryIn};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Operation select with zero defaults for codes this core does not own.
    always_comb begin
        result   = '0;
        carryOut = 1'b0;
        overflow = 1'b0;
        case (aluOp)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                {carryOut, result} = w_sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // carryOut=1 means no borrow
                {carryOut, result} = w_diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq_unit.sv
//------------------------------------------------------------------------------
// Module      : alu_seq_unit
// Description : Registered ALU with valid/ready on both sides, status flags
//               and bit-serial shifts. Build option ALU_MUL_EN adds an
//               unsigned shift-add multiply on op 101 (illegal otherwise).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    input  logic [2:0]       aluOp,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero,
    output logic             illegalOp
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] c_countOne = (SHW+1)'(1);
    localparam logic [SHW:0] c_countMul = (SHW+1)'(WIDTH);

    aluState_t        r_state;
    aluState_t        w_nextState;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [SHW:0]     r_count;

    logic             w_accept;
    logic [SHW-1:0]   w_shamt;
    logic             w_isShift;
    logic             w_startsExec;
    logic             w_illegal;
    logic             w_lastStep;
    logic [WIDTH-1:0] w_coreResult;
    logic             w_coreCarry;
    logic             w_coreOverflow;
    logic [WIDTH-1:0] w_immResult;
    logic [WIDTH-1:0] w_stepAcc;
    logic             w_stepCarry;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_prodHi;
    logic [WIDTH-1:0] w_stepHi;
    logic [WIDTH:0]   w_mulSum;
`endif

    alu_comb_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a        (a),
        .b        (b),
        .carryIn  (carryIn),
        .aluOp    (aluOp),
        .result   (w_coreResult),
        .carryOut (w_coreCarry),
        .overflow (w_coreOverflow)
    );

    assign w_accept   = inValid && inReady;
    assign w_shamt    = b[SHW-1:0];
    assign w_isShift  = (aluOp == OP_SLL) || (aluOp == OP_SRL);
    assign w_lastStep = (r_state == EXEC) && (r_count == c_countOne);
    // A zero-amount shift completes immediately with the operand unchanged.
    assign w_immResult = w_isShift ? a : w_coreResult;

`ifdef ALU_MUL_EN
    assign w_startsExec = (w_isShift && (w_shamt != '0)) || (aluOp == OP_MUL);
    assign w_illegal    = 1'b0;
`else
    assign w_startsExec = w_isShift && (w_shamt != '0);
    assign w_illegal    = (aluOp == OP_MUL);
`endif

    // One iteration of the running serial op.
    always_comb begin
        w_stepAcc   = r_acc;
        w_stepCarry = 1'b0;
`ifdef ALU_MUL_EN
        w_stepHi    = r_prodHi;
        w_mulSum    = '0;
`endif
        case (r_op)
            OP_SLL: begin
                w_stepAcc   = {r_acc[WIDTH-2:0], 1'b0};
                w_stepCarry = r_acc[WIDTH-1];
            end
            OP_SRL: begin
                w_stepAcc   = {1'b0, r_acc[WIDTH-1:1]};
                w_stepCarry = r_acc[0];
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                // {prodHi, acc} shifts right; acc starts as the multiplier.
                w_mulSum    = {1'b0, r_prodHi} + ({1'b0, r_mcand} & {(WIDTH+1){r_acc[0]}});
                w_stepHi    = w_mulSum[WIDTH:1];
                w_stepAcc   = {w_mulSum[0], r_acc[WIDTH-1:1]};
                w_stepCarry = |w_mulSum[WIDTH:1];
            end
`endif
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_nextState = r_state;
        inReady     = 1'b0;
        outValid    = 1'b0;
        case (r_state)
            IDLE: begin
                inReady = rst_n;
                if (w_accept) begin
                    w_nextState = w_startsExec ? EXEC : HOLD;
                end
            end
            EXEC: begin
                if (w_lastStep) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                outValid = 1'b1;
                if (outReady) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Operand capture, serial iteration and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            result    <= '0;
            carryOut  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            illegalOp <= 1'b0;
`ifdef ALU_MUL_EN
            r_mcand   <= '0;
            r_prodHi  <= '0;
`endif
        end else if (w_accept) begin
            r_op      <= aluOp;
            illegalOp <= w_illegal;
            r_count   <= {1'b0, w_shamt};
            r_acc     <= a;
`ifdef ALU_MUL_EN
            r_mcand   <= a;
            r_prodHi  <= '0;
            if (aluOp == OP_MUL) begin
                r_acc   <= b;
                r_count <= c_countMul;
            end
`endif
            if (!w_startsExec) begin
                result   <= w_immResult;
                carryOut <= w_coreCarry;
                overflow <= w_coreOverflow;
                zero     <= (w_immResult == '0);
            end
        end else if (r_state == EXEC) begin
            r_acc   <= w_stepAcc;
            r_count <= r_count - c_countOne;
`ifdef ALU_MUL_EN
            r_prodHi <= w_stepHi;
`endif
            if (w_lastStep) begin
                result   <= w_stepAcc;
                carryOut <= w_stepCarry;
                overflow <= 1'b0;
                zero     <= (w_stepAcc == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_seq_unit
// Description : Scoreboard bench for alu_seq_unit (WIDTH=32). Expectations
//               come from an arithmetic reference model; honours ALU_MUL_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq_unit;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         ov;
        logic         z;
        logic         ill;
        int           lat;
        int           acceptEdge;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryIn;
    logic [2:0]   aluOp;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] result;
    logic         carryOut;
    logic         overflow;
    logic         zero;
    logic         illegalOp;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   edgeCnt = 0;
    int   bpMode = 0;   // 0: always ready, 1: random, 2: stalled

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .a         (a),
        .b         (b),
        .carryIn   (carryIn),
        .aluOp     (aluOp),
        .outValid  (outValid),
        .outReady  (outReady),
        .result    (result),
        .carryOut  (carryOut),
        .overflow  (overflow),
        .zero      (zero),
        .illegalOp (illegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt++;

    // Consumer-side ready, changed shortly after each rising edge.
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            outReady = (bpMode == 0) ? 1'b1 : (bpMode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each op.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic cin);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      s;
        logic [63:0] wide;
        int          sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y[4:0]);
        e.res = '0; e.cy = 1'b0; e.ov = 1'b0; e.ill = 1'b0; e.lat = 1; e.acceptEdge = 0;
        case (op)
            3'b000: e.res = x & y;
            3'b001: e.res = x | y;
            3'b010: begin
                wide  = 64'(x) + 64'(y) + 64'(cin);
                e.res = wide[W-1:0];
                e.cy  = wide[W];
                s     = sx + sy + longint'(cin);
                e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                e.res = x - y;
                e.cy  = (x >= y);
                s     = sx - sy;
                e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b111: e.res = (sx < sy) ? 32'd1 : 32'd0;
            3'b011: begin
                wide  = 64'(x) << sh;
                e.res = wide[W-1:0];
                e.cy  = (sh != 0) && wide[W];
                e.lat = 1 + sh;
            end
            3'b100: begin
                e.res = x >> sh;
                if (sh != 0) begin
                    wide = 64'(x) >> (sh - 1);
                    e.cy = wide[0];
                end
                e.lat = 1 + sh;
            end
            default: begin
`ifdef ALU_MUL_EN
                wide  = 64'(x) * 64'(y);
                e.res = wide[W-1:0];
                e.cy  = (wide[63:32] != 0);
                e.lat = W + 1;
`else
                e.ill = 1'b1;
`endif
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Present one op; push its expectation when it is accepted.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic cin);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        aluOp = op; a = x; b = y; carryIn = cin; inValid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (inReady) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL accept_timeout: got inReady=0 expected 1 within 200 cycles");
            inValid = 1'b0;
            return;
        end
        e = model(op, x, y, cin);
        e.acceptEdge = edgeCnt + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        // Scramble inputs: the unit must have latched them.
        a = $urandom; b = $urandom; carryIn = 1'($urandom); aluOp = 3'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 5000; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    bit prevValid = 1'b0;
    bit prevHs = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prevValid = 1'b0;
            prevHs = 1'b0;
        end else begin
            if (prevHs) check("inReady_after_handshake", 32'(inReady), 32'd1);
            if (outValid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: got result %h expected no output", result);
                end else begin
                    e = sb[0];
                    if (!prevValid) check("latency", 32'(edgeCnt - e.acceptEdge + 1), 32'(e.lat));
                    check("result",    result,           e.res);
                    check("carryOut",  32'(carryOut),    32'(e.cy));
                    check("overflow",  32'(overflow),    32'(e.ov));
                    check("zero",      32'(zero),        32'(e.z));
                    check("illegalOp", 32'(illegalOp),   32'(e.ill));
                    check("inReady_in_hold", 32'(inReady), 32'd0);
                    if (outReady) void'(sb.pop_front());
                end
            end
            prevHs    = outValid && outReady;
            prevValid = outValid && !outReady;
        end
    end

    initial begin
        rst_n = 1'b0; inValid = 1'b0; a = '0; b = '0; carryIn = 1'b0; aluOp = '0;
        repeat (3) @(negedge clk);
        check("rst_outValid",  32'(outValid),  32'd0);
        check("rst_result",    result,         32'd0);
        check("rst_carryOut",  32'(carryOut),  32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        check("rst_illegalOp", 32'(illegalOp), 32'd0);
        check("rst_inReady",   32'(inReady),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_inReady", 32'(inReady), 32'd1);

        // Directed cases
        issue(3'b010, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        issue(3'b110, 32'd5, 32'd7, 1'b1);
        issue(3'b111, 32'hA0000000, 32'hB0000000, 1'b0);
        issue(3'b110, 32'h2A2A2A2A, 32'h2A2A2A2A, 1'b0);
        issue(3'b100, 32'h0000000F, 32'd2, 1'b0);
        issue(3'b011, 32'h12345678, 32'hFFFFFFE0, 1'b0);
        issue(3'b011, 32'h80000001, 32'd31, 1'b0);
        issue(3'b101, 32'h00010000, 32'h00010001, 1'b0);
        issue(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
        issue(3'b010, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        drain();

        // Backpressure: result held, no second accept while stalled.
        bpMode = 2;
        @(posedge clk);
        #3;
        issue(3'b010, 32'h12345678, 32'h0F0F0F0F, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (outValid) break;
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_outValid", 32'(outValid), 32'd1);
            check("bp_inReady",  32'(inReady),  32'd0);
            if (i == 1) begin
                aluOp = 3'b001; a = 32'h55555555; b = 32'h0000AAAA; inValid = 1'b1;
                @(posedge clk);
                #1;
                inValid = 1'b0;
            end
            @(negedge clk);
        end
        bpMode = 0;
        issue(3'b110, 32'h00000010, 32'h00000020, 1'b0);
        drain();

        // Randomized traffic with random consumer stalls.
        bpMode = 1;
        for (int n = 0; n < 80; n++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            if ($urandom_range(0, 5) == 0) x = {1'b0, x[W-2:0]} | 32'h7FFF0000;
            issue(3'($urandom_range(0, 7)), x, y, 1'($urandom));
        end
        drain();
        bpMode = 0;
        @(posedge clk);
        #3;

        // Reset in the middle of a long shift.
        issue(3'b011, 32'hDEADBEEF, 32'd20, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outValid",  32'(outValid),  32'd0);
        check("midrst_result",    result,         32'd0);
        check("midrst_carryOut",  32'(carryOut),  32'd0);
        check("midrst_overflow",  32'(overflow),  32'd0);
        check("midrst_zero",      32'(zero),      32'd0);
        check("midrst_illegalOp", 32'(illegalOp), 32'd0);
        check("midrst_inReady",   32'(inReady),   32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_inReady", 32'(inReady), 32'd1);
        issue(3'b010, 32'd1, 32'd1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
